// File: rtl/seq_pair_tx_if.sv
// Frame-load handshake and symbol-stream bundle for seq_pair_tx.
// The master side offers frame words and hold; the slave side (the transmitter)
// returns the handshake, the A/B symbol pair and the frame status.
interface seq_pair_tx_if #(
    parameter int unsigned NSYM = 8
);
    logic                load_valid;
    logic [2*NSYM-1:0]   load_data;
    logic                load_ready;
    logic                hold;
    logic                A;
    logic                B;
    logic                sym_valid;
    logic                busy;
    logic                done;
    logic [7:0]          frame_cnt;

    modport master (
        output load_valid, load_data, hold,
        input  load_ready, A, B, sym_valid, busy, done, frame_cnt
    );

    modport slave (
        input  load_valid, load_data, hold,
        output load_ready, A, B, sym_valid, busy, done, frame_cnt
    );
endinterface

// File: rtl/seq_pair_tx.sv
// Serialises a 2*NSYM-bit frame word onto the A/B pair, one 2-bit symbol per
// cycle, symbol 0 first. Supports a hold stall, an optional idle gap after
// each frame, a one-cycle done pulse and a wrapping completed-frame counter.
module seq_pair_tx #(
    parameter int unsigned NSYM    = 8,
    parameter int unsigned GAP_CYC = 1
) (
    input  logic          clk,
    input  logic          reset,
    seq_pair_tx_if.slave  bus
);
    localparam int unsigned W  = 2 * NSYM;
    // Counter must also hold NSYM, the "all symbols emitted" value.
    localparam int unsigned CW = $clog2(NSYM + 1);

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    shift_q, shift_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      gap_q, gap_d;
    logic            a_q, a_d;
    logic            b_q, b_d;
    logic            sym_valid_q, sym_valid_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;

    // Ready is decoded from the registered state and gated by reset so it
    // drops in the very cycle reset is asserted.
    assign bus.load_ready = reset && (state_q == StIdle);
    assign bus.A          = a_q;
    assign bus.B          = b_q;
    assign bus.sym_valid  = sym_valid_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
    assign bus.frame_cnt  = frame_cnt_q;

    // Next-state and next-output decode; outputs are registered, so each
    // decision here becomes visible in the following cycle.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        a_d         = 1'b0;
        b_d         = 1'b0;
        sym_valid_d = 1'b0;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (bus.load_valid) begin
                    // Symbol 0 is registered straight from the word so it
                    // appears the cycle after acceptance; the shift register
                    // keeps the remaining symbols and the count restarts.
                    a_d         = bus.load_data[W-1];
                    b_d         = bus.load_data[W-2];
                    sym_valid_d = 1'b1;
                    shift_d     = {bus.load_data[W-3:0], 2'b00};
                    cnt_d       = CW'(1);
                    state_d     = StSend;
                end
            end
            StSend: begin
                if (cnt_q == CW'(NSYM)) begin
                    // Last symbol is on the wire now: close the frame.
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    shift_d     = '0;
                    cnt_d       = '0;
                    if (GAP_CYC > 0) begin
                        state_d = StGap;
                        gap_d   = 4'(GAP_CYC - 1);
                    end else begin
                        state_d = StIdle;
                    end
                end else if (!bus.hold) begin
                    a_d         = shift_q[W-1];
                    b_d         = shift_q[W-2];
                    sym_valid_d = 1'b1;
                    shift_d     = {shift_q[W-3:0], 2'b00};
                    cnt_d       = cnt_q + CW'(1);
                end
            end
            StGap: begin
                if (gap_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            sym_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sym_valid_q <= sym_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end
endmodule

// File: tb/tb_seq_pair_tx.sv
// Bench for seq_pair_tx: two instances (gap of 1 and gap of 0) checked every
// cycle against a frame-level reference model, plus directed frame checks.
module tb_seq_pair_tx;
    localparam int unsigned NSYM = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    seq_pair_tx_if #(.NSYM(NSYM)) bus1 ();
    seq_pair_tx_if #(.NSYM(NSYM)) bus0 ();

    seq_pair_tx #(.NSYM(NSYM), .GAP_CYC(1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    seq_pair_tx #(.NSYM(NSYM), .GAP_CYC(0)) u_dut_b2b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, index 0 = gap-0 instance, 1 = gap-1 instance.
    // mode: 0 idle, 1 sending, 2 gap.
    int unsigned m_mode [2];
    int unsigned m_idx  [2];
    int unsigned m_gapl [2];
    int unsigned m_fc   [2];
    logic [15:0] m_word [2];
    logic [1:0]  e_sym  [2];
    bit          e_sv   [2];
    bit          e_done [2];

    logic [1:0] got1 [$];

    // Back-to-back monitor for the gap-0 instance.
    bit b2b_on = 1'b0;
    bit b2b_seen = 1'b0;
    int b2b_zero = 0;
    int b2b_runs = 0;
    int b2b_bad = 0;
    int dones0 = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] sym_of(input logic [15:0] word, input int unsigned i);
        logic [15:0] s;
        s = word >> (2 * (NSYM - 1 - i));
        return s[1:0];
    endfunction

    task automatic model_step(input int k, input int unsigned gapc, input bit r, input bit lv,
                              input logic [15:0] ld, input bit hd);
        e_sym[k]  = 2'b00;
        e_sv[k]   = 1'b0;
        e_done[k] = 1'b0;
        if (!r) begin
            m_mode[k] = 0;
            m_idx[k]  = 0;
            m_fc[k]   = 0;
            m_gapl[k] = 0;
            return;
        end
        case (m_mode[k])
            0: if (lv) begin
                m_word[k] = ld;
                e_sym[k]  = sym_of(ld, 0);
                e_sv[k]   = 1'b1;
                m_idx[k]  = 1;
                m_mode[k] = 1;
            end
            1: if (m_idx[k] == NSYM) begin
                e_done[k] = 1'b1;
                m_fc[k]   = (m_fc[k] + 1) % 256;
                if (gapc > 0) begin
                    m_mode[k] = 2;
                    m_gapl[k] = gapc;
                end else begin
                    m_mode[k] = 0;
                end
            end else if (!hd) begin
                e_sym[k] = sym_of(m_word[k], m_idx[k]);
                e_sv[k]  = 1'b1;
                m_idx[k] = m_idx[k] + 1;
            end
            default: begin
                m_gapl[k] = m_gapl[k] - 1;
                if (m_gapl[k] == 0) m_mode[k] = 0;
            end
        endcase
    endtask

    task automatic compare_outs(input int k, input logic a, input logic b, input logic sv,
                                input logic dn, input logic bsy, input logic rdy,
                                input logic [7:0] fc);
        string p;
        p = (k == 0) ? "b2b" : "main";
        check_eq({p, "_sym"}, 32'({a, b, sv}), 32'({e_sym[k], e_sv[k]}));
        check_eq({p, "_done"}, 32'(dn), 32'(e_done[k]));
        check_eq({p, "_busy"}, 32'(bsy), 32'(m_mode[k] != 0));
        check_eq({p, "_ready"}, 32'(rdy), 32'((m_mode[k] == 0) && reset));
        check_eq({p, "_fcnt"}, 32'(fc), m_fc[k]);
    endtask

    // One clock: sample inputs, advance model on the edge, compare #1 later.
    task automatic tick();
        bit r, lv0, lv1, h0, h1;
        logic [15:0] ld0, ld1;
        r   = reset;
        lv0 = bus0.load_valid;
        ld0 = bus0.load_data;
        h0  = bus0.hold;
        lv1 = bus1.load_valid;
        ld1 = bus1.load_data;
        h1  = bus1.hold;
        @(posedge clk);
        model_step(0, 0, r, lv0, ld0, h0);
        model_step(1, 1, r, lv1, ld1, h1);
        #1;
        compare_outs(0, bus0.A, bus0.B, bus0.sym_valid, bus0.done, bus0.busy,
                     bus0.load_ready, bus0.frame_cnt);
        compare_outs(1, bus1.A, bus1.B, bus1.sym_valid, bus1.done, bus1.busy,
                     bus1.load_ready, bus1.frame_cnt);
        if (bus1.sym_valid) got1.push_back({bus1.A, bus1.B});
        if (b2b_on) begin
            if (bus0.done) dones0++;
            if (bus0.sym_valid) begin
                if (b2b_seen && b2b_zero != 0) begin
                    b2b_runs++;
                    if (b2b_zero != 1) b2b_bad++;
                end
                b2b_seen = 1'b1;
                b2b_zero = 0;
            end else if (b2b_seen) begin
                b2b_zero++;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && !bus1.load_ready; i++) tick();
        check_eq("idle_reached", 32'(bus1.load_ready), 32'd1);
    endtask

    task automatic accept(input logic [15:0] word);
        got1.delete();
        bus1.load_valid = 1'b1;
        bus1.load_data  = word;
        tick();
        bus1.load_valid = 1'b0;
    endtask

    task automatic run_to_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (bus1.done) seen = 1'b1;
        end
        check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [15:0] word);
        check_eq({tag, "_nsym"}, got1.size(), NSYM);
        for (int i = 0; i < got1.size() && i < NSYM; i++)
            check_eq($sformatf("%s_s%0d", tag, i), 32'(got1[i]), 32'(word[15-2*i -: 2]));
    endtask

    initial begin
        logic [15:0] w_basic;
        w_basic = 16'hB4E1;
        bus0.load_valid = 1'b0;
        bus0.load_data  = '0;
        bus0.hold       = 1'b0;
        bus1.load_valid = 1'b0;
        bus1.load_data  = '0;
        bus1.hold       = 1'b0;

        // Reset state, with load_valid offered to prove reset priority.
        bus1.load_valid = 1'b1;
        bus1.load_data  = 16'hFFFF;
        repeat (3) tick();
        check_eq("rst_ready", 32'(bus1.load_ready), 32'd0);
        bus1.load_valid = 1'b0;
        reset = 1'b1;
        tick();

        // Basic frame: 10,11,01,00,11,10,00,01.
        accept(w_basic);
        check_eq("lat1_sym0", 32'({bus1.sym_valid, bus1.A, bus1.B}), 32'b110);
        run_to_done("basic");
        check_frame("basic", w_basic);
        check_eq("basic_fcnt", 32'(bus1.frame_cnt), 32'd1);
        tick();
        check_eq("basic_ready_after_gap", 32'(bus1.load_ready), 32'd1);

        // Stall over symbols 2 and 3 for three cycles.
        drain();
        accept(w_basic);
        tick();
        bus1.hold = 1'b1;
        repeat (3) begin
            tick();
            check_eq("stall_quiet", 32'({bus1.sym_valid, bus1.A, bus1.B}), 32'd0);
        end
        bus1.hold = 1'b0;
        run_to_done("stall");
        check_frame("stall", w_basic);

        // Load offered while busy must not disturb the frame in flight.
        drain();
        accept(w_basic);
        repeat (3) tick();
        bus1.load_valid = 1'b1;
        bus1.load_data  = 16'hFFFF;
        tick();
        bus1.load_valid = 1'b0;
        run_to_done("busy_rej");
        check_frame("busy_rej", w_basic);

        // Reset abort at symbol 4, then a clean frame.
        drain();
        accept(w_basic);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_eq("abort_fcnt", 32'(bus1.frame_cnt), 32'd0);
        check_eq("abort_outs", 32'({bus1.sym_valid, bus1.done, bus1.busy}), 32'd0);
        reset = 1'b1;
        tick();
        accept(16'h0003);
        run_to_done("post_abort");
        check_frame("post_abort", 16'h0003);

        // Loopback frame: first 11 symbol lands at index 2.
        drain();
        accept(16'h8F00);
        run_to_done("loop");
        check_frame("loop", 16'h8F00);

        // Randomised traffic with hold and occasional reset.
        for (int i = 0; i < 800; i++) begin
            bus1.load_valid = ($urandom_range(0, 2) == 0);
            bus1.load_data  = 16'($urandom);
            bus1.hold       = ($urandom_range(0, 3) == 0);
            reset           = ($urandom_range(0, 59) != 0);
            tick();
        end
        bus1.load_valid = 1'b0;
        bus1.hold = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // 256 back-to-back frames on the gap-0 instance.
        b2b_on = 1'b1;
        bus0.load_valid = 1'b1;
        for (int i = 0; i < 256 * 12 && dones0 < 256; i++) begin
            bus0.load_data = 16'($urandom);
            tick();
        end
        bus0.load_valid = 1'b0;
        check_eq("b2b_dones", dones0, 32'd256);
        check_eq("b2b_wrap_fcnt", 32'(bus0.frame_cnt), 32'd0);
        check_eq("b2b_runs", b2b_runs, 32'd255);
        check_eq("b2b_bad_gaps", b2b_bad, 32'd0);
        b2b_on = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_pair_tx.md
SEQ_PAIR_TX -- requirements
Module: seq_pair_tx

Interface
REQ-001 The block SHALL have parameter NSYM, default 8: number of 2-bit symbols per frame, legal range 2..16.
REQ-002 The block SHALL have parameter GAP_CYC, default 1: idle cycles inserted after each frame, legal range 0..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 The block SHALL have port load_valid, input, 1 bit: a frame word is offered.
REQ-006 The block SHALL have port load_data, input, 2*NSYM bits: frame word, symbol 0 in the two MSBs.
REQ-007 The block SHALL have port load_ready, output, 1 bit: the block can accept a frame word.
REQ-008 The block SHALL have port hold, input, 1 bit: pause the symbol stream.
REQ-009 The block SHALL have port A, output, 1 bit: current symbol, high bit.
REQ-010 The block SHALL have port B, output, 1 bit: current symbol, low bit.
REQ-011 The block SHALL have port sym_valid, output, 1 bit: A/B carry a frame symbol this cycle.
REQ-012 The block SHALL have port busy, output, 1 bit: a frame is in progress (SEND or GAP).
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle frame-complete pulse.
REQ-014 The block SHALL have port frame_cnt, output, 8 bits: count of completed frames.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SEND and GAP.
REQ-016 load_ready SHALL be 1 only in IDLE with reset high.
REQ-017 Acceptance SHALL occur on a cycle with load_valid=1 and load_ready=1: load_data is captured into the shift register, the symbol counter is cleared, and the state becomes SEND on the next cycle.
REQ-018 load_valid SHALL be ignored whenever load_ready=0; the held word SHALL not be overwritten.
REQ-019 In SEND with hold=0: A equals shift[MSB], B equals shift[MSB-1], and sym_valid=1.
REQ-020 In SEND with hold=0: the register shifts left by 2 with zero fill, and the counter increments.
REQ-021 The first symbol SHALL appear on the cycle after acceptance, giving a latency of 1.
REQ-022 In SEND with hold=1: A=0, B=0 and sym_valid=0; the shift register and counter are frozen; no symbol is lost or duplicated.
REQ-023 hold SHALL have no effect in IDLE or GAP.
REQ-024 After the symbol with counter = NSYM-1 is emitted: the next state is GAP if GAP_CYC>0, otherwise IDLE.
REQ-025 done SHALL pulse for exactly one cycle, on the first cycle after the last symbol.
REQ-026 frame_cnt SHALL increment in that same cycle, wrapping from 255 to 0.
REQ-027 In GAP: A=0, B=0, sym_valid=0, and the state remains for exactly GAP_CYC cycles before IDLE.
REQ-028 With GAP_CYC=0 and load_valid held high, frames SHALL be back-to-back except for the single IDLE acceptance cycle.
REQ-029 busy SHALL be 1 in SEND and GAP, and 0 in IDLE.
REQ-030 In IDLE: A=0, B=0 and sym_valid=0.
REQ-031 A, B, sym_valid, done, busy and frame_cnt SHALL be registered outputs; load_ready MAY be decoded from the registered state.

Reset
REQ-032 While reset=0 at a clock edge: the state SHALL become IDLE; A, B, sym_valid, done and busy SHALL become 0; frame_cnt SHALL become 0; the shift register and counter SHALL be cleared.
REQ-033 load_ready SHALL be 0 during any cycle with reset=0.
REQ-034 Reset asserted mid-SEND or mid-GAP SHALL abort the frame: no done pulse and no frame_cnt increment.
REQ-035 After reset release, the first accepted frame SHALL start cleanly from symbol 0.
REQ-036 Reset SHALL have priority over load_valid and hold.

Verification
REQ-037 Basic frame: NSYM=8, GAP_CYC=1, load_data=16'hB4E1 accepted at cycle t -> cycles t+1..t+8 give A,B = 10,11,01,00,11,10,00,01 with sym_valid=1; done=1 at t+9; frame_cnt=1; load_ready=1 at t+10.
REQ-038 Stall: same frame with hold=1 during emission of symbols 2 and 3 for 3 cycles -> sym_valid=0 and A=B=0 for those 3 cycles; sequence resumes at symbol 2; done is delayed by 3 cycles; all 8 symbols are seen exactly once.
REQ-039 Busy rejection: load_valid pulsed with 16'hFFFF during SEND -> no effect; the original frame completes unchanged.
REQ-040 Reset abort: reset=0 for 1 cycle at symbol 4 -> next cycle all outputs are 0, frame_cnt=0, no done pulse; a new frame 16'h0003 then emits 00 x7 followed by 11.
REQ-041 Wrap and back-to-back: GAP_CYC=0, 256 consecutive frames with load_valid held high -> frame_cnt returns to 0; frames are separated by exactly one sym_valid=0 cycle.
REQ-042 Detector loopback: frame 16'h8F00 (symbols 10,00,11,11,00,00,00,00) driven into the team's A/B sequence detector -> detector Y=1 on the cycle of the first 11 symbol.
